tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter N, default 4: number of DUT inputs swept, 1..8.
REQ-002 Parameter HOLD, default 10: clock cycles each input vector is held, >=1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin sweep; sampled only in IDLE or DONE.
REQ-006 abort  input  1  cancel sweep in progress; return to IDLE.
REQ-007 vec  output  N  stimulus vector to DUT inputs (MSB = first listed input).
REQ-008 resp  input  1  DUT output, sampled at end of each hold window.
REQ-009 expect_tt  input  2**N  expected truth table; bit i = expected resp for vec==i.
REQ-010 tt  output  2**N  captured truth table; bit i = resp sampled for vec==i.
REQ-011 mismatch_cnt  output  N+1  count of bits where captured differs from expect_tt.
REQ-012 busy  output  1  sweep in progress.
REQ-013 done  output  1  sweep completed; held until next start or reset.
REQ-014 pass  output  1  done && mismatch_cnt==0.

Function
REQ-015 States: IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after last sample, RUN->IDLE on abort, DONE->RUN on start.
REQ-016 On start accepted at edge k: vec=0, hold counter=0, tt=0, mismatch_cnt=0, busy=1, done=0.
REQ-017 In RUN, hold counter increments each cycle; at edge where counter==HOLD-1, resp captured into tt[vec], mismatch_cnt increments if resp!=expect_tt[vec], counter clears, vec increments.
REQ-018 Sample edges are k+HOLD, k+2*HOLD, ..., k+(2**N)*HOLD; total sweep = (2**N)*HOLD cycles.
REQ-019 At the sample edge with vec==2**N-1: state->DONE, busy=0, done=1, vec wraps to 0; no further samples.
REQ-020 expect_tt read only at sample edges; changes between samples have no effect.
REQ-021 start while busy ignored; start and abort together in IDLE/DONE: abort wins, state IDLE.
REQ-022 abort in RUN: state IDLE at next edge, busy=0, done=0, vec=0; tt and mismatch_cnt hold partial values.
REQ-023 abort coinciding with final sample edge: abort wins, done stays 0.
REQ-024 mismatch_cnt cannot overflow (N+1 bits covers 2**N).
REQ-025 All outputs registered; vec changes only at edges.

Reset
REQ-026 rst high at an edge: state IDLE, vec=0, tt=0, mismatch_cnt=0, busy=0, done=0, pass=0, hold counter=0.
REQ-027 rst dominates start and abort; reset mid-sweep discards all partial results.

Structure
REQ-028 Package tt_sweep_pkg holds the state enum and width constants/functions (2**N, counter width clog2(HOLD)).
REQ-029 One sub-module tt_hold_timer: parametrised HOLD down/up counter with clear and one-cycle tick output.
REQ-030 Target 150-300 RTL lines; no memories, truth table in flops.

Verification
REQ-031 N=4, HOLD=10, resp=a&b&c&d, expect_tt=16'h8000, start pulse -> tt=16'h8000, mismatch_cnt=0, done and pass high exactly 160 cycles after start edge.
REQ-032 Same, expect_tt=16'h8001 -> tt=16'h8000, mismatch_cnt=1, done=1, pass=0.
REQ-033 N=2, HOLD=1, resp=XOR -> vec 0,1,2,3 on consecutive cycles, tt=4'b0110, done after 4 cycles.
REQ-034 start pulsed again at cycle 50 of run -> ignored; done still at cycle 160, counts unchanged.
REQ-035 abort at cycle 75 -> IDLE next edge, busy=0, done=0, tt bits 0..6 captured, bits 7..15 zero.
REQ-036 rst at cycle 80 with start high -> all outputs zero, state IDLE; a subsequent start gives full 160-cycle sweep.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared state encoding and width helpers for the truth-table sweeper
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of truth-table rows for an n-input sweep.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

   // A hold of one cycle still needs a 1-bit counter.
   function automatic int cnt_width(input int hold);
      return (hold <= 1) ? 1 : $clog2(hold);
   endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// rtl/tt_hold_timer.sv - counts HOLD cycles per vector and pulses tick on the last one
module tt_hold_timer
   import tt_sweep_pkg::*;
#(
   parameter int HOLD = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int CW = cnt_width(HOLD);
   localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   assign tick = en && (count == LAST);

endmodule

// File: rtl/tt_sweep.sv
// rtl/tt_sweep.sv - sweeps all 2**N input vectors, captures the response and compares
// it against an expected truth table.
module tt_sweep
   import tt_sweep_pkg::*;
#(
   parameter int N    = 4,
   parameter int HOLD = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            abort,
   output logic [N-1:0]    vec,
   input  logic            resp,
   input  logic [2**N-1:0] expect_tt,
   output logic [2**N-1:0] tt,
   output logic [N:0]      mismatch_cnt,
   output logic            busy,
   output logic            done,
   output logic            pass
);

   localparam int TTW = tt_width(N);

   state_t     state;
   logic       tick;
   logic       sample;
   logic       hit;
   logic [N:0] mc_next;

   tt_hold_timer #(.HOLD(HOLD)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (state != ST_RUN),
      .en    ((state == ST_RUN) && !abort),
      .tick  (tick)
   );

   // The timer is disabled on abort, so a tick is always a real sample edge.
   assign sample = tick;

   always_comb begin
      hit     = resp != expect_tt[vec];
      mc_next = mismatch_cnt + {{N{1'b0}}, hit};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         vec          <= '0;
         tt           <= '0;
         mismatch_cnt <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (abort) begin
                  state <= ST_IDLE;
                  vec   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end else if (sample) begin
                  tt[vec]      <= resp;
                  mismatch_cnt <= mc_next;
                  if (vec == N'(TTW - 1)) begin
                     state <= ST_DONE;
                     vec   <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (mc_next == '0);
                  end else begin
                     vec <= vec + N'(1);
                  end
               end
            end
            default: begin
               // IDLE and DONE behave alike: abort beats start, results are kept.
               if (abort) begin
                  state <= ST_IDLE;
                  vec   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end else if (start) begin
                  state        <= ST_RUN;
                  vec          <= '0;
                  tt           <= '0;
                  mismatch_cnt <= '0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  pass         <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep.sv
// tb/tb_tt_sweep.sv - self-checking bench for tt_sweep (N=4/HOLD=10 and N=2/HOLD=1)
module tb_tt_sweep;

   localparam int NA   = 4;
   localparam int HA   = 10;
   localparam int TTWA = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int resp_mode = 0;

   logic        start_a = 1'b0;
   logic        abort_a = 1'b0;
   logic [3:0]  vec_a;
   logic        resp_a;
   logic [15:0] exp_a = 16'h8000;
   logic [15:0] tt_a;
   logic [4:0]  mc_a;
   logic        busy_a, done_a, pass_a;

   logic        start_b = 1'b0;
   logic [1:0]  vec_b;
   logic        resp_b;
   logic [3:0]  tt_b;
   logic [2:0]  mc_b;
   logic        busy_b, done_b, pass_b;

   function automatic logic f_resp(input int mode, input int v);
      if (mode == 1) return 1'b1;
      return (v == 15);
   endfunction

   assign resp_a = f_resp(resp_mode, int'(vec_a));
   assign resp_b = vec_b[1] ^ vec_b[0];

   tt_sweep #(.N(NA), .HOLD(HA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .vec(vec_a),
      .resp(resp_a), .expect_tt(exp_a), .tt(tt_a), .mismatch_cnt(mc_a),
      .busy(busy_a), .done(done_a), .pass(pass_a)
   );

   tt_sweep #(.N(2), .HOLD(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .vec(vec_b),
      .resp(resp_b), .expect_tt(4'b0110), .tt(tt_b), .mismatch_cnt(mc_b),
      .busy(busy_b), .done(done_b), .pass(pass_b)
   );

   // Model: position within the sweep is tracked as elapsed cycles since start.
   logic [3:0]  m_vec = '0;
   logic [15:0] m_tt = '0;
   logic [4:0]  m_mc = '0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_pass = 1'b0;
   int          m_cyc = 0;

   always @(posedge clk) begin
      int  idx;
      logic r;
      if (rst) begin
         m_vec = '0; m_tt = '0; m_mc = '0;
         m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
      end else if (m_busy) begin
         if (abort_a) begin
            m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0; m_vec = '0;
         end else begin
            m_cyc++;
            if (m_cyc % HA == 0) begin
               idx = m_cyc / HA - 1;
               r = f_resp(resp_mode, idx);
               m_tt[idx] = r;
               if (r != exp_a[idx]) m_mc++;
               if (idx == TTWA - 1) begin
                  m_busy = 1'b0; m_done = 1'b1; m_vec = '0;
                  m_pass = (m_mc == 0);
               end else begin
                  m_vec = 4'(m_cyc / HA);
               end
            end
         end
      end else if (abort_a) begin
         m_done = 1'b0; m_pass = 1'b0; m_vec = '0;
      end else if (start_a) begin
         m_busy = 1'b1; m_done = 1'b0; m_pass = 1'b0;
         m_cyc = 0; m_tt = '0; m_mc = '0; m_vec = '0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if ({vec_a, tt_a, mc_a, busy_a, done_a, pass_a} !==
             {m_vec, m_tt, m_mc, m_busy, m_done, m_pass}) begin
            errors++;
            $display("FAIL model_cmp t=%0t actual vec=%h tt=%h mc=%0d busy=%b done=%b pass=%b required vec=%h tt=%h mc=%0d busy=%b done=%b pass=%b",
                     $time, vec_a, tt_a, mc_a, busy_a, done_a, pass_a,
                     m_vec, m_tt, m_mc, m_busy, m_done, m_pass);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic pulse_start_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int n0, output int n);
      n = n0;
      while (!done_a && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!done_a) begin
         errors++;
         $display("FAIL done_timeout actual=0 required=1");
      end
   endtask

   int n;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("reset_out", {vec_a, tt_a, mc_a, busy_a, done_a, pass_a}, 32'h0);

      // Basic AND sweep, matching expectation
      pulse_start_a();
      chk("busy_after_start", busy_a, 1);
      wait_done_a(0, n);
      chk("done_latency", n, 160);
      chk("tt_and", tt_a, 32'h8000);
      chk("mc_and", mc_a, 0);
      chk("pass_and", pass_a, 1);

      // One expected bit wrong, restarted from DONE
      exp_a = 16'h8001;
      pulse_start_a();
      wait_done_a(0, n);
      chk("tt_8001", tt_a, 32'h8000);
      chk("mc_8001", mc_a, 1);
      chk("pass_8001", pass_a, 0);
      chk("done_8001", done_a, 1);

      // Second start mid-run is ignored
      exp_a = 16'h8000;
      pulse_start_a();
      repeat (49) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      wait_done_a(50, n);
      chk("restart_ignored_latency", n, 160);
      chk("restart_ignored_mc", mc_a, 0);

      // Abort at cycle 75 with constant-1 response
      resp_mode = 1;
      pulse_start_a();
      repeat (74) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk) abort_a = 1'b0;
      chk("abort75_busy", busy_a, 0);
      chk("abort75_done", done_a, 0);
      chk("abort75_tt", tt_a, 32'h007F);
      chk("abort75_mc", mc_a, 7);

      // Abort on the final sample edge wins
      pulse_start_a();
      repeat (159) @(negedge clk);
      abort_a = 1'b1;
      @(negedge clk) abort_a = 1'b0;
      chk("abort_last_done", done_a, 0);
      chk("abort_last_tt", tt_a, 32'h7FFF);
      chk("abort_last_mc", mc_a, 15);

      // Reset at cycle 80 with start held high
      resp_mode = 0;
      pulse_start_a();
      repeat (79) @(negedge clk);
      rst = 1'b1; start_a = 1'b1;
      @(negedge clk);
      chk("rst_mid_out", {vec_a, tt_a, mc_a, busy_a, done_a, pass_a}, 32'h0);
      rst = 1'b0; start_a = 1'b0;
      pulse_start_a();
      wait_done_a(0, n);
      chk("post_rst_latency", n, 160);
      chk("post_rst_pass", pass_a, 1);

      // start and abort together in DONE: abort wins
      @(negedge clk) begin start_a = 1'b1; abort_a = 1'b1; end
      @(negedge clk) begin start_a = 1'b0; abort_a = 1'b0; end
      chk("start_abort_busy", busy_a, 0);
      chk("start_abort_done", done_a, 0);

      // expect_tt wobbling between samples; model reads it only at sample edges
      pulse_start_a();
      n = 0;
      while (!done_a && n < 400) begin
         exp_a = 16'($urandom);
         @(negedge clk);
         n++;
      end
      chk("wobble_latency", n, 160);

      // N=2, HOLD=1, XOR response
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b_vec%0d", i), vec_b, i);
         chk($sformatf("b_busy%0d", i), busy_b, 1);
         @(negedge clk);
      end
      chk("b_done", done_b, 1);
      chk("b_tt", tt_b, 32'h6);
      chk("b_mc", mc_b, 0);
      chk("b_pass", pass_b, 1);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
